// File: rtl/tqvp_xga_timing_gen.sv
// Raster timing generator for the TinyQV sprite renderer: counters, syncs, active flag, IRQs.
// Optional line-compare interrupt is built when XGA_TIMING_LINE_IRQ_EN is defined.
module tqvp_xga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter bit          SYNC_NEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  irq_clr,
  input  logic [9:0]  line_cmp,
  output logic [10:0] h_cnt,
  output logic [9:0]  v_cnt,
  output logic        hsync_r,
  output logic        vsync_r,
  output logic        visible_r,
  output logic        line_start,
  output logic        frame_start,
  output logic        irq_vblank,
  output logic        irq_line
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_W  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        visible_q, visible_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        irq_vblank_q, irq_vblank_d;
  logic        irq_line_q, irq_line_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: everything is derived from the next count so all flops stay aligned.
  // Entering RUN restarts at (0,0); leaving RUN drops straight back to 0 without finishing the frame.
  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (state_d == RUN && state_q == RUN) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
      end
    end

    hsync_d       = SYNC_NEG;
    vsync_d       = SYNC_NEG;
    visible_d     = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (state_d == RUN) begin
      hsync_d       = ((h_cnt_d >= HS_START) && (h_cnt_d < HS_END)) ^ SYNC_NEG;
      vsync_d       = ((v_cnt_d >= VS_START) && (v_cnt_d < VS_END)) ^ SYNC_NEG;
      visible_d     = (h_cnt_d < H_ACT_W) && (v_cnt_d < V_ACT_W);
      line_start_d  = (h_cnt_d == 11'd0);
      frame_start_d = (h_cnt_d == 11'd0) && (v_cnt_d == 10'd0);
    end

    // Set has priority over a coincident clear.
    irq_vblank_d = (line_start_d && (v_cnt_d == V_ACT_W)) || (irq_vblank_q && !irq_clr[0]);
  end

`ifdef XGA_TIMING_LINE_IRQ_EN
  // line_cmp values beyond V_TOTAL-1 never match because v_cnt never gets there.
  always_comb begin
    irq_line_d = (line_start_d && (v_cnt_d == line_cmp)) || (irq_line_q && !irq_clr[1]);
  end
`else
  logic unused_line_in;
  assign unused_line_in = ^{line_cmp, irq_clr[1]};
  assign irq_line_d     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= SYNC_NEG;
      vsync_q       <= SYNC_NEG;
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      irq_vblank_q  <= 1'b0;
      irq_line_q    <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      irq_vblank_q  <= irq_vblank_d;
      irq_line_q    <= irq_line_d;
    end
  end

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign hsync_r     = hsync_q;
  assign vsync_r     = vsync_q;
  assign visible_r   = visible_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign irq_vblank  = irq_vblank_q;
  assign irq_line    = irq_line_q;

endmodule

// File: tb/tb_tqvp_xga_timing_gen.sv
// Directed bench for tqvp_xga_timing_gen on a shrunk raster (28x18 totals) to keep runs short.
module tb_tqvp_xga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 6;
  localparam int VA = 12, VF = 1, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 28
  localparam int VT = VA + VF + VS + VB;   // 18
  localparam int FRAME = HT * VT;          // 504

  logic        clk, rst_n, en;
  logic [1:0]  irq_clr;
  logic [9:0]  line_cmp;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        hsync_r, vsync_r, visible_r, line_start, frame_start, irq_vblank, irq_line;

  int errors = 0;
  int checks = 0;

  tqvp_xga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_NEG(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .irq_clr(irq_clr), .line_cmp(line_cmp),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .hsync_r(hsync_r), .vsync_r(vsync_r),
    .visible_r(visible_r), .line_start(line_start), .frame_start(frame_start),
    .irq_vblank(irq_vblank), .irq_line(irq_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int eh, ev, evb, eline, vis_cnt, fs_cnt, fs_first, fs_second, seen_line;
    rst_n = 1'b0; en = 1'b1; irq_clr = 2'b00; line_cmp = 10'd5;
    step(); step();
    chk("rst h_cnt", h_cnt, 0);
    chk("rst v_cnt", v_cnt, 0);
    chk("rst hsync", hsync_r, 1);
    chk("rst vsync", vsync_r, 1);
    chk("rst visible", visible_r, 0);
    chk("rst line_start", line_start, 0);
    chk("rst frame_start", frame_start, 0);
    chk("rst irq_vblank", irq_vblank, 0);
    chk("rst irq_line", irq_line, 0);

    rst_n = 1'b1;
    step();
    chk("first h_cnt", h_cnt, 0);
    chk("first v_cnt", v_cnt, 0);
    chk("first frame_start", frame_start, 1);
    chk("first line_start", line_start, 1);

    // Two full frames checked cycle by cycle against an independent raster model.
    eh = 0; ev = 0; evb = 0; eline = 0;
    vis_cnt = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (eh == 0 && ev == VA) evb = 1;
`ifdef XGA_TIMING_LINE_IRQ_EN
      if (eh == 0 && ev == 5) eline = 1;
`endif
      chk("run h_cnt", h_cnt, eh);
      chk("run v_cnt", v_cnt, ev);
      chk("run hsync", hsync_r, (eh >= 18 && eh < 22) ? 0 : 1);
      chk("run vsync", vsync_r, (ev >= 13 && ev < 15) ? 0 : 1);
      chk("run visible", visible_r, (eh < 16 && ev < 12) ? 1 : 0);
      chk("run line_start", line_start, (eh == 0) ? 1 : 0);
      chk("run frame_start", frame_start, (eh == 0 && ev == 0) ? 1 : 0);
      chk("run irq_vblank", irq_vblank, evb);
      chk("run irq_line", irq_line, eline);
      if (visible_r) vis_cnt++;
      if (frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      step();
      if (eh == HT - 1) begin
        eh = 0;
        ev = (ev == VT - 1) ? 0 : ev + 1;
      end else eh++;
    end
    chk("visible cycles 2 frames", vis_cnt, 384);
    chk("frame_start count", fs_cnt, 2);
    chk("frame_start period", fs_second - fs_first, 504);

    // Clear both flags away from their set points.
    irq_clr = 2'b11;
    step();
    irq_clr = 2'b00;
    chk("clr h_cnt", h_cnt, 1);
    chk("clr irq_vblank", irq_vblank, 0);
    chk("clr irq_line", irq_line, 0);

    // Clear coinciding with the vblank set edge: set wins.
    repeat (334) step();
    chk("pre-vblank h_cnt", h_cnt, 27);
    chk("pre-vblank v_cnt", v_cnt, 11);
    irq_clr = 2'b01;
    step();
    irq_clr = 2'b00;
    chk("vblank h_cnt", h_cnt, 0);
    chk("vblank v_cnt", v_cnt, 12);
    chk("set-wins irq_vblank", irq_vblank, 1);
    irq_clr = 2'b01;
    step();
    irq_clr = 2'b00;
    chk("clr2 irq_vblank", irq_vblank, 0);

    // Drop en mid-frame, then restart.
    repeat (345) step();
    chk("pre-drop h_cnt", h_cnt, 10);
    chk("pre-drop v_cnt", v_cnt, 6);
    en = 1'b0;
    step();
    chk("idle h_cnt", h_cnt, 0);
    chk("idle v_cnt", v_cnt, 0);
    chk("idle frame_start", frame_start, 0);
    chk("idle line_start", line_start, 0);
    chk("idle visible", visible_r, 0);
    chk("idle hsync", hsync_r, 1);
    chk("idle vsync", vsync_r, 1);
    step();
    chk("idle2 h_cnt", h_cnt, 0);
    en = 1'b1;
    step();
    chk("restart h_cnt", h_cnt, 0);
    chk("restart v_cnt", v_cnt, 0);
    chk("restart frame_start", frame_start, 1);
    chk("restart line_start", line_start, 1);
    chk("restart visible", visible_r, 1);
    step();
    chk("restart+1 h_cnt", h_cnt, 1);
    chk("restart+1 frame_start", frame_start, 0);

    // Asynchronous reset mid-line.
    repeat (5) step();
    chk("pre-areset h_cnt", h_cnt, 6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("areset h_cnt", h_cnt, 0);
    chk("areset visible", visible_r, 0);
    chk("areset line_start", line_start, 0);
    #1;
    rst_n = 1'b1;
    step();
    chk("post-areset h_cnt", h_cnt, 0);
    chk("post-areset frame_start", frame_start, 1);

    // Out-of-range compare value never fires.
    line_cmp = 10'd20;
    seen_line = 0;
    for (int i = 0; i < FRAME + 10; i++) begin
      if (irq_line) seen_line = 1;
      step();
    end
    chk("line_cmp out of range", seen_line, 0);
    chk("vblank after frame", irq_vblank, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
